// File: rtl/mic_rx_stereo.sv
// Stereo audio-ADC serial receiver.
// Deserialises adcdat on bclk using adclrc framing (left-justified or I2S), captures both
// channels of every frame and presents one left/right pair per frame with a valid strobe.
// Half-frames that end before N bits were taken raise a one-cycle frame_err instead.
module mic_rx_stereo #(
    parameter int unsigned N        = 16,   // sample width per channel, 8..32
    parameter int unsigned MODE     = 0,    // 0: left-justified, 1: I2S (one-bit delay)
    parameter logic        LEFT_POL = 1'b1  // adclrc level of the left half-frame
) (
    input  logic         bclk,
    input  logic         rst_n,
    input  logic         adclrc,
    input  logic         adcdat,
    output logic [N-1:0] left_data,
    output logic [N-1:0] right_data,
    output logic         valid,
    output logic         frame_err
);

    localparam int unsigned CntW = $clog2(N + 2);

    // cnt counts bits taken in the current half-frame; N means complete, N+1 is the
    // saturated "complete and already acknowledged" value.
    localparam logic [CntW-1:0] CntFull  = CntW'(N);
    localparam logic [CntW-1:0] CntSat   = CntW'(N + 1);
    // Left-justified takes the MSB in the edge cycle itself, I2S takes nothing there.
    localparam logic [CntW-1:0] CntStart = (MODE == 0) ? CntW'(1) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StLeft,
        StRight
    } state_e;

    state_e          state_q;
    logic            lrc_q;
    logic            primed_q;
    logic [CntW-1:0] cnt_q;
    logic [N-1:0]    shift_l_q;
    logic [N-1:0]    shift_r_q;
    logic            left_ok_q;
    logic [N-1:0]    left_data_q;
    logic [N-1:0]    right_data_q;
    logic            valid_q;
    logic            frame_err_q;

    logic            lrc_edge;
    logic            edge_is_left;
    logic            in_half;
    logic            half_short;
    logic            take_bit;
    logic            pair_done;
    logic [N-1:0]    first_word;

    // Edge detection and per-cycle capture decisions.
    always_comb begin
        lrc_edge     = primed_q && (adclrc != lrc_q);
        edge_is_left = (adclrc == LEFT_POL);
        in_half      = (state_q != StIdle);
        // A new edge arriving before N bits were taken cuts the running half-frame short.
        half_short   = lrc_edge && in_half && (cnt_q < CntFull);
        take_bit     = !lrc_edge && in_half && (cnt_q < CntFull);
        // cnt sits at N for exactly one cycle after the right LSB, so this fires once.
        pair_done    = (state_q == StRight) && (cnt_q == CntFull) && left_ok_q;
        first_word   = (MODE == 0) ? {{(N - 1){1'b0}}, adcdat} : '0;
    end

    // Framing FSM, bit counter, shift registers and registered outputs.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lrc_q        <= 1'b0;
            primed_q     <= 1'b0;
            cnt_q        <= '0;
            shift_l_q    <= '0;
            shift_r_q    <= '0;
            left_ok_q    <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            lrc_q       <= adclrc;
            primed_q    <= 1'b1;
            valid_q     <= pair_done;
            frame_err_q <= half_short;

            // Shift registers are read before any restart below overwrites them.
            if (pair_done) begin
                left_data_q  <= shift_l_q;
                right_data_q <= shift_r_q;
            end

            if (lrc_edge) begin
                if (edge_is_left) begin
                    state_q   <= StLeft;
                    cnt_q     <= CntStart;
                    shift_l_q <= first_word;
                end else if (in_half) begin
                    state_q   <= StRight;
                    cnt_q     <= CntStart;
                    shift_r_q <= first_word;
                    // The pair is only delivered if the left half just ending was full.
                    left_ok_q <= (state_q == StLeft) && !half_short;
                end
                // A right edge in idle is ignored: the partial frame after reset is dropped.
            end else if (in_half) begin
                if (take_bit) begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (state_q == StLeft) begin
                        shift_l_q <= {shift_l_q[N-2:0], adcdat};
                    end else begin
                        shift_r_q <= {shift_r_q[N-2:0], adcdat};
                    end
                end else if (cnt_q == CntFull) begin
                    cnt_q <= CntSat;
                end
            end
        end
    end

    assign left_data  = left_data_q;
    assign right_data = right_data_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_mic_rx_stereo.sv
// Self-checking bench for mic_rx_stereo: three instances (16-bit left-justified, 24-bit I2S
// with inverted LEFT_POL, 32-bit left-justified) driven one at a time, scoreboard-checked.
module tb_mic_rx_stereo;

    typedef struct {
        int          id;
        logic [31:0] l;
        logic [31:0] r;
        int          due;
    } exp_t;

    logic       bclk = 1'b0;
    logic [2:0] rstn_s = 3'b000;
    logic [2:0] lrc_s = 3'b000;
    logic [2:0] dat_s = 3'b000;

    logic [15:0] left0, right0;
    logic [23:0] left1, right1;
    logic [31:0] left2, right2;
    logic        valid0, valid1, valid2;
    logic        ferr0, ferr1, ferr2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    int   vcnt[3];
    int   ecnt[3];
    int   ecyc[3];
    int   expv[3];
    logic pv[3];

    always #5 bclk = ~bclk;
    always @(posedge bclk) cyc <= cyc + 1;

    mic_rx_stereo #(.N(16), .MODE(0), .LEFT_POL(1'b1)) dut0 (
        .bclk(bclk), .rst_n(rstn_s[0]), .adclrc(lrc_s[0]), .adcdat(dat_s[0]),
        .left_data(left0), .right_data(right0), .valid(valid0), .frame_err(ferr0)
    );
    mic_rx_stereo #(.N(24), .MODE(1), .LEFT_POL(1'b0)) dut1 (
        .bclk(bclk), .rst_n(rstn_s[1]), .adclrc(lrc_s[1]), .adcdat(dat_s[1]),
        .left_data(left1), .right_data(right1), .valid(valid1), .frame_err(ferr1)
    );
    mic_rx_stereo #(.N(32), .MODE(0), .LEFT_POL(1'b1)) dut2 (
        .bclk(bclk), .rst_n(rstn_s[2]), .adclrc(lrc_s[2]), .adcdat(dat_s[2]),
        .left_data(left2), .right_data(right2), .valid(valid2), .frame_err(ferr2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic fe,
                       input logic [31:0] l, input logic [31:0] r);
        exp_t e;
        if (v) begin
            vcnt[id]++;
            chk("valid_ferr_excl", fe, 1'b0);
            chk("valid_single", pv[id], 1'b0);
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pair_id", id, e.id);
                chk("left_data", l, e.l);
                chk("right_data", r, e.r);
                chk("valid_cycle", cyc, e.due);
            end
        end
        if (fe) begin
            ecnt[id]++;
            ecyc[id] = cyc;
        end
        pv[id] = v;
    endtask

    // Outputs are sampled on the falling edge, half a period away from capture.
    always @(negedge bclk) begin
        mon(0, valid0, ferr0, {16'b0, left0}, {16'b0, right0});
        mon(1, valid1, ferr1, {8'b0, left1}, {8'b0, right1});
        mon(2, valid2, ferr2, left2, right2);
    end

    // Drive one half-frame of len bclk at level lvl; optionally push the frame's pair.
    task automatic drive_half(input int id, input int n, input int mode, input logic lvl,
                              input logic [31:0] word, input int len, input bit push,
                              input logic [31:0] pl, input logic [31:0] pr,
                              output int edge_cyc);
        exp_t e;
        int   lat;
        edge_cyc = 0;
        lat = (mode == 0) ? n : n + 1;
        for (int i = 0; i < len; i++) begin
            @(negedge bclk);
            lrc_s[id] = lvl;
            if (mode == 0) begin
                dat_s[id] = (i < n) ? word[n-1-i] : 1'($urandom);
            end else if (i == 0) begin
                dat_s[id] = ~word[n-1];  // stray bit chosen to corrupt the MSB if taken
            end else begin
                dat_s[id] = (i <= n) ? word[n-i] : 1'($urandom);
            end
            if (i == 0) begin
                edge_cyc = cyc + 1;
                if (push) begin
                    e.id  = id;
                    e.l   = pl;
                    e.r   = pr;
                    e.due = edge_cyc + lat;
                    sb.push_back(e);
                    expv[id]++;
                end
            end
        end
    endtask

    task automatic run_frame(input int id, input int n, input int mode, input logic pol,
                             input int hl, input int hr, input logic [31:0] l,
                             input logic [31:0] r, input bit push, output int e_right);
        int el;
        drive_half(id, n, mode, pol, l, hl, 1'b0, l, r, el);
        drive_half(id, n, mode, ~pol, r, hr, push, l, r, e_right);
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge bclk);
    endtask

    initial begin
        #100_000_0;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        int          er;
        int          e0;
        int          v2;
        logic [31:0] l, r, last_l, last_r;

        for (int i = 0; i < 3; i++) begin
            vcnt[i] = 0; ecnt[i] = 0; ecyc[i] = 0; expv[i] = 0; pv[i] = 1'b0;
        end

        // Reset values
        #12;
        chk("rst_left0", left0, 16'h0);     chk("rst_right0", right0, 16'h0);
        chk("rst_valid0", valid0, 1'b0);    chk("rst_ferr0", ferr0, 1'b0);
        chk("rst_left1", left1, 24'h0);     chk("rst_right1", right1, 24'h0);
        chk("rst_valid1", valid1, 1'b0);    chk("rst_ferr1", ferr1, 1'b0);
        chk("rst_left2", left2, 32'h0);     chk("rst_right2", right2, 32'h0);
        chk("rst_valid2", valid2, 1'b0);    chk("rst_ferr2", ferr2, 1'b0);

        @(negedge bclk);
        rstn_s[0] = 1'b1;
        rstn_s[1] = 1'b1;
        idle(3);

        // Left-justified, 16-bit, 32 bclk halves
        run_frame(0, 16, 0, 1'b1, 32, 32, 32'hA5C3, 32'h1234, 1'b1, er);
        run_frame(0, 16, 0, 1'b1, 32, 32, 32'hA5C3, 32'h1234, 1'b1, er);
        run_frame(0, 16, 0, 1'b1, 32, 32, 32'h0F0F, 32'hF00D, 1'b1, er);
        last_l = 32'h0F0F;
        last_r = 32'hF00D;
        chk("lj_no_ferr", ecnt[0], 0);

        // Short left half (10 bclk): one frame_err at the right edge, outputs held
        e0 = ecnt[0];
        run_frame(0, 16, 0, 1'b1, 10, 32, 32'hDEAD, 32'hBEEF, 1'b0, er);
        chk("short_ferr_count", ecnt[0] - e0, 1);
        chk("short_ferr_cycle", ecyc[0], er);
        chk("short_hold_left", left0, last_l[15:0]);
        chk("short_hold_right", right0, last_r[15:0]);
        run_frame(0, 16, 0, 1'b1, 32, 32, 32'h5A5A, 32'hC001, 1'b1, er);
        chk("after_short_ferr", ecnt[0] - e0, 1);

        // Async reset in the middle of a right half-frame
        run_frame(0, 16, 0, 1'b1, 32, 8, 32'h1111, 32'h2222, 1'b0, er);
        #2;
        rstn_s[0] = 1'b0;
        #1;
        chk("arst_left0", left0, 16'h0);    chk("arst_right0", right0, 16'h0);
        chk("arst_valid0", valid0, 1'b0);   chk("arst_ferr0", ferr0, 1'b0);
        idle(2);
        rstn_s[0] = 1'b1;
        drive_half(0, 16, 0, 1'b0, 32'h3333, 20, 1'b0, 0, 0, er);
        run_frame(0, 16, 0, 1'b1, 32, 32, 32'hCAFE, 32'h7777, 1'b1, er);
        idle(4);

        // I2S, 24-bit, left = low level, stray bit in every edge cycle
        idle(2);
        drive_half(1, 24, 1, 1'b1, 32'h0, 10, 1'b0, 0, 0, er);
        run_frame(1, 24, 1, 1'b0, 32, 32, 32'h800001, 32'h7FFFFE, 1'b1, er);
        run_frame(1, 24, 1, 1'b0, 32, 32, 32'h800001, 32'h7FFFFE, 1'b1, er);
        l = $urandom & 32'hFFFFFF;
        r = $urandom & 32'hFFFFFF;
        run_frame(1, 24, 1, 1'b0, 25, 25, l, r, 1'b1, er);
        idle(4);

        // 32-bit: reset released mid right half, then two frames
        drive_half(2, 32, 0, 1'b1, 32'h0, 32, 1'b0, 0, 0, er);
        drive_half(2, 32, 0, 1'b0, 32'h0, 10, 1'b0, 0, 0, er);
        rstn_s[2] = 1'b1;
        drive_half(2, 32, 0, 1'b0, 32'hFFFF_FFFF, 22, 1'b0, 0, 0, er);
        run_frame(2, 32, 0, 1'b1, 32, 32, 32'hFFFF_0001, 32'h8000_7FFF, 1'b1, er);
        run_frame(2, 32, 0, 1'b1, 32, 32, 32'h1357_9BDF, 32'h2468_ACE0, 1'b1, er);
        idle(4);
        chk("partial_then_two", vcnt[2], 2);

        // 100 random back-to-back frames
        v2 = vcnt[2];
        for (int f = 0; f < 100; f++) begin
            l = $urandom;
            r = $urandom;
            run_frame(2, 32, 0, 1'b1, 32, 32, l, r, 1'b1, er);
        end
        idle(4);
        chk("random_valid_count", vcnt[2] - v2, 100);

        chk("sb_drained", sb.size(), 0);
        chk("vcnt0", vcnt[0], expv[0]);
        chk("vcnt1", vcnt[1], expv[1]);
        chk("vcnt2", vcnt[2], expv[2]);
        chk("ferr_total0", ecnt[0], 1);
        chk("ferr_total1", ecnt[1], 0);
        chk("ferr_total2", ecnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
